// File: rtl/cmd_pkg.sv
// Shared TRS-80 CMD file definitions: record type bytes, chunk size and the
// saver FSM state encoding (also imported by the loader).
package cmd_pkg;

  localparam logic [7:0] REC_DATA  = 8'h01;
  localparam logic [7:0] REC_XFR   = 8'h02;
  localparam int         MAX_CHUNK = 256;

  typedef enum logic [3:0] {
    IDLE,
    REC_TYPE,
    REC_LEN,
    REC_ALO,
    REC_AHI,
    DATA_FETCH,
    DATA_OUT,
    XFR_TYPE,
    XFR_LEN,
    XFR_LO,
    XFR_HI,
    DONE
  } cmd_state_t;

endpackage

// File: rtl/cmd_saver.sv
// Streams a RAM range to a host as a TRS-80 CMD file, one byte per up_rd.
// Header/transfer bytes answer in one cycle; data bytes take a RAM read first.
module cmd_saver
  import cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        save_go_i,
  input  logic [15:0] start_addr_i,
  input  logic [15:0] end_addr_i,
  input  logic [15:0] exec_addr_i,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  input  logic        up_rd_i,
  output logic        up_wait_o,
  output logic [7:0]  up_din_o,
  output logic [16:0] file_size_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [3:0]  state_o
);

  // Host handshake: a byte request is the one-cycle up_rd pulse; while
  // up_wait is high the request is still in flight and further up_rd is ignored.
  cmd_state_t  state_q;
  logic [16:0] addr_q;
  logic [16:0] end_q;
  logic [15:0] exec_q;
  logic [8:0]  cnt_q;
  logic [7:0]  up_din_q;
  logic        up_wait_q;
  logic        mem_rd_q;
  logic [15:0] mem_addr_q;
  logic [16:0] file_size_q;
  logic        busy_q;
  logic        err_q;

  logic [16:0] n_bytes_d;
  logic [16:0] n_chunks_d;
  logic [16:0] size_d;
  logic [16:0] remain_d;
  logic [8:0]  chunk_n_d;
  logic        rd_ok;

  always_comb begin
    n_bytes_d  = {1'b0, end_addr_i} - {1'b0, start_addr_i} + 17'd1;
    n_chunks_d = (n_bytes_d + 17'd255) >> 8;
    size_d     = n_bytes_d + (n_chunks_d << 2) + 17'd4;
    remain_d   = end_q - addr_q + 17'd1;
    chunk_n_d  = (remain_d >= 17'd256) ? 9'd256 : remain_d[8:0];
    rd_ok      = up_rd_i && !up_wait_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      end_q       <= '0;
      exec_q      <= '0;
      cnt_q       <= '0;
      up_din_q    <= '0;
      up_wait_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      file_size_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_ok) up_din_q <= 8'h00;
          if (save_go_i) begin
            if (end_addr_i < start_addr_i) begin
              err_q <= 1'b1;
            end else begin
              addr_q      <= {1'b0, start_addr_i};
              end_q       <= {1'b0, end_addr_i};
              exec_q      <= exec_addr_i;
              file_size_q <= size_d;
              busy_q      <= 1'b1;
              state_q     <= REC_TYPE;
            end
          end
        end
        REC_TYPE: if (rd_ok) begin
          up_din_q <= REC_DATA;
          state_q  <= REC_LEN;
        end
        REC_LEN: if (rd_ok) begin
          // A full 256-byte chunk wraps the length byte to 0x02.
          up_din_q <= chunk_n_d[7:0] + 8'd2;
          cnt_q    <= chunk_n_d;
          state_q  <= REC_ALO;
        end
        REC_ALO: if (rd_ok) begin
          up_din_q <= addr_q[7:0];
          state_q  <= REC_AHI;
        end
        REC_AHI: if (rd_ok) begin
          up_din_q <= addr_q[15:8];
          state_q  <= DATA_FETCH;
        end
        DATA_FETCH: if (rd_ok) begin
          mem_rd_q   <= 1'b1;
          mem_addr_q <= addr_q[15:0];
          up_wait_q  <= 1'b1;
          state_q    <= DATA_OUT;
        end
        DATA_OUT: begin
          // The cycle mem_rd is high the RAM has not answered yet.
          if (!mem_rd_q) begin
            up_din_q  <= mem_data_i;
            up_wait_q <= 1'b0;
            addr_q    <= addr_q + 17'd1;
            cnt_q     <= cnt_q - 9'd1;
            if (cnt_q == 9'd1)
              state_q <= (addr_q == end_q) ? XFR_TYPE : REC_TYPE;
            else
              state_q <= DATA_FETCH;
          end
        end
        XFR_TYPE: if (rd_ok) begin
          up_din_q <= REC_XFR;
          state_q  <= XFR_LEN;
        end
        XFR_LEN: if (rd_ok) begin
          up_din_q <= 8'h02;
          state_q  <= XFR_LO;
        end
        XFR_LO: if (rd_ok) begin
          up_din_q <= exec_q[7:0];
          state_q  <= XFR_HI;
        end
        XFR_HI: if (rd_ok) begin
          up_din_q <= exec_q[15:8];
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          if (rd_ok) up_din_q <= 8'h00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign up_wait_o   = up_wait_q;
  assign up_din_o    = up_din_q;
  assign file_size_o = file_size_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cmd_saver.sv
// Bench for cmd_saver: RAM model, host read driver, and a byte-stream
// reference built from the CMD record rules.
module tb_cmd_saver;
  import cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        save_go = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [15:0] exec_addr = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        up_rd = 1'b0;
  logic        up_wait;
  logic [7:0]  up_din;
  logic [16:0] file_size;
  logic        busy;
  logic        err;
  logic [3:0]  state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ram [0:65535];
  int mon_lo = 0, mon_hi = 0, mon_next = 0, mem_rd_cnt = 0;

  cmd_saver dut (
    .clk_i(clk), .rst_i(rst), .save_go_i(save_go),
    .start_addr_i(start_addr), .end_addr_i(end_addr), .exec_addr_i(exec_addr),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .up_rd_i(up_rd), .up_wait_o(up_wait), .up_din_o(up_din),
    .file_size_o(file_size), .busy_o(busy), .err_o(err), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM answers exactly one cycle after the read strobe; junk otherwise.
  always @(posedge clk) mem_data <= (mem_rd === 1'b1) ? ram[mem_addr] : 8'h5A;

  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      mem_rd_cnt++;
      check("mem_addr", {16'h0, mem_addr}, mon_next);
      check("mem_range", {31'h0, (int'(mem_addr) >= mon_lo && int'(mem_addr) <= mon_hi)}, 1);
      mon_next++;
    end
  end

  task automatic read_byte(input bit spam, output logic [7:0] b, output int lat);
    @(negedge clk);
    up_rd = 1'b1;
    @(negedge clk);
    up_rd = 1'b0;
    lat = 1;
    if (spam && up_wait === 1'b1) begin
      up_rd = 1'b1;
      @(negedge clk);
      up_rd = 1'b0;
      lat++;
    end
    while (up_wait === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    b = up_din;
  endtask

  task automatic pulse_go(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x);
    start_addr = s;
    end_addr   = e;
    exec_addr  = x;
    save_go    = 1'b1;
    @(negedge clk);
    save_go    = 1'b0;
  endtask

  task automatic run_save(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x,
                          input bit spam_ok);
    logic [7:0] exp_q[$];
    bit         dat_q[$];
    logic [7:0] b;
    int         lat, a, n, ei, nb, fs;
    a  = int'(s);
    ei = int'(e);
    nb = ei - a + 1;
    while (a <= ei) begin
      n = (ei - a + 1 > MAX_CHUNK) ? MAX_CHUNK : ei - a + 1;
      exp_q.push_back(8'h01);           dat_q.push_back(1'b0);
      exp_q.push_back(8'((n + 2) % 256)); dat_q.push_back(1'b0);
      exp_q.push_back(8'(a % 256));     dat_q.push_back(1'b0);
      exp_q.push_back(8'(a / 256));     dat_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(ram[a + i]);
        dat_q.push_back(1'b1);
      end
      a += n;
    end
    exp_q.push_back(8'h02); dat_q.push_back(1'b0);
    exp_q.push_back(8'h02); dat_q.push_back(1'b0);
    exp_q.push_back(x[7:0]); dat_q.push_back(1'b0);
    exp_q.push_back(x[15:8]); dat_q.push_back(1'b0);
    fs = nb + 4 * ((nb + 255) / 256) + 4;

    mon_lo = int'(s); mon_hi = ei; mon_next = int'(s); mem_rd_cnt = 0;
    @(negedge clk);
    pulse_go(s, e, x);
    check("file_size", {15'h0, file_size}, fs);
    check("file_len", fs, exp_q.size());
    check("busy_start", {31'h0, busy}, 1);
    // A bad-range request while busy is ignored without err.
    pulse_go(16'h0001, 16'h0000, 16'h0000);
    check("go_busy_err", {31'h0, err}, 0);
    check("go_busy_busy", {31'h0, busy}, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == exp_q.size() - 1) check("busy_last", {31'h0, busy}, 1);
      read_byte(spam_ok && ($urandom_range(0, 3) == 0), b, lat);
      check($sformatf("byte%0d", i), {24'h0, b}, {24'h0, exp_q[i]});
      check($sformatf("lat%0d", i), {31'h0, (lat <= (dat_q[i] ? 3 : 1))}, 1);
    end
    @(negedge clk);
    check("busy_end", {31'h0, busy}, 0);
    check("state_end", {28'h0, state}, {28'h0, IDLE});
    check("mem_rd_cnt", mem_rd_cnt, nb);
    read_byte(1'b0, b, lat);
    check("past_end_byte", {24'h0, b}, 0);
    check("past_end_lat", lat, 1);
    check("past_end_rd", mem_rd_cnt, nb);
  endtask

  initial begin
    logic [7:0] b;
    int lat, s, e, snap;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h5200] = 8'hAA; ram[16'h5201] = 8'hBB; ram[16'h5202] = 8'hCC;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_mem_rd", {31'h0, mem_rd}, 0);
    check("rst_mem_addr", {16'h0, mem_addr}, 0);
    check("rst_up_wait", {31'h0, up_wait}, 0);
    check("rst_up_din", {24'h0, up_din}, 0);
    check("rst_file_size", {15'h0, file_size}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_err", {31'h0, err}, 0);
    check("rst_state", {28'h0, state}, {28'h0, IDLE});

    run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);
    check("fs_3b", {15'h0, file_size}, 11);
    run_save(16'h6000, 16'h60FF, 16'h6010, 1'b1);
    check("fs_256", {15'h0, file_size}, 264);
    run_save(16'h6000, 16'h6100, 16'h6000, 1'b1);
    check("fs_257", {15'h0, file_size}, 269);
    run_save(16'hFF00, 16'hFFFF, 16'h1234, 1'b1);
    check("fs_top", {15'h0, file_size}, 264);

    // Rejected range
    @(negedge clk);
    pulse_go(16'h7000, 16'h6FFF, 16'h7000);
    check("bad_err", {31'h0, err}, 1);
    check("bad_busy", {31'h0, busy}, 0);
    check("bad_state", {28'h0, state}, {28'h0, IDLE});
    @(negedge clk);
    check("bad_err_once", {31'h0, err}, 0);
    read_byte(1'b0, b, lat);
    check("bad_rd_byte", {24'h0, b}, 0);
    check("bad_rd_wait", {31'h0, up_wait}, 0);

    // Reset part-way through the data of a record
    mon_lo = 'h5200; mon_hi = 'h52FF; mon_next = 'h5200; mem_rd_cnt = 0;
    @(negedge clk);
    pulse_go(16'h5200, 16'h52FF, 16'h5200);
    for (int i = 0; i < 10; i++) read_byte(1'b0, b, lat);
    check("pre_rst_byte", {24'h0, b}, {24'h0, ram[16'h5205]});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {28'h0, state}, {28'h0, IDLE});
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_mem_rd", {31'h0, mem_rd}, 0);
    snap = mem_rd_cnt;
    read_byte(1'b0, b, lat);
    check("abort_byte", {24'h0, b}, 0);
    check("abort_no_rd", mem_rd_cnt, snap);
    run_save(16'h5200, 16'h5202, 16'h5200, 1'b0);

    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 65535);
      e = s + $urandom_range(1, 600) - 1;
      if (e > 65535) e = 65535;
      run_save(16'(s), 16'(e), 16'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmd_saver.md
CMD_SAVER -- requirements
Module: cmd_saver

Interface
REQ-001 clock  in  1  system clock (clk_sys domain); all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 save_go  in  1  one-cycle start pulse; sampled only in IDLE.
REQ-004 start_addr  in  16  first RAM address to save; captured on accepted save_go.
REQ-005 end_addr  in  16  last RAM address to save, inclusive; captured on accepted save_go.
REQ-006 exec_addr  in  16  transfer (entry) address; captured on accepted save_go.
REQ-007 mem_rd  out  1  one-cycle RAM read strobe.
REQ-008 mem_addr  out  16  RAM read address; valid while mem_rd=1.
REQ-009 mem_data  in  8  RAM read data; valid exactly 1 cycle after mem_rd.
REQ-010 up_rd  in  1  one-cycle host request for the next file byte.
REQ-011 up_wait  out  1  high while the requested byte is not yet on up_din.
REQ-012 up_din  out  8  current file byte; valid when up_wait=0 after an up_rd; held until the next up_rd.
REQ-013 file_size  out  17  total CMD file length in bytes; valid from the cycle after save_go is accepted.
REQ-014 busy  out  1  high from accepted save_go until the last byte is delivered.
REQ-015 err  out  1  one-cycle pulse when save_go is rejected.

Function
REQ-016 The output stream SHALL be a TRS-80 CMD file: one or more data records, then one transfer record.
REQ-017 Data record SHALL be 0x01, L, addr_lo, addr_hi, then n data bytes; n = 1..256; L = (n+2) mod 256, so 0x02 for n=256.
REQ-018 Records SHALL split the range into consecutive 256-byte chunks from start_addr; only the last chunk may be shorter.
REQ-019 Transfer record SHALL be 0x02, 0x02, exec_lo, exec_hi.
REQ-020 file_size SHALL equal N + 4*ceil(N/256) + 4, where N = end_addr - start_addr + 1 (1..65536).
REQ-021 save_go with end_addr < start_addr SHALL be rejected: err pulses, state stays IDLE, busy stays 0.
REQ-022 FSM states SHALL be IDLE, REC_TYPE, REC_LEN, REC_ALO, REC_AHI, DATA_FETCH, DATA_OUT, XFR_TYPE, XFR_LEN, XFR_LO, XFR_HI, DONE.
REQ-023 Each up_rd SHALL advance exactly one byte position; header and transfer bytes SHALL be on up_din the cycle after up_rd, with up_wait=0.
REQ-024 For a data byte, up_rd SHALL cause mem_rd one cycle later at the current address; up_wait SHALL be high from the cycle after up_rd until mem_data is registered onto up_din. Latency SHALL be at most 3 cycles.
REQ-025 The address counter SHALL be 17 bits internally so that end_addr=0xFFFF terminates without wrap to 0x0000.
REQ-026 After the final byte (exec_hi), busy SHALL drop the following cycle and the state SHALL return to IDLE through DONE.
REQ-027 up_rd in IDLE, or beyond the end of the file, SHALL return 0x00 with up_wait=0 and SHALL NOT issue mem_rd.
REQ-028 up_rd asserted while up_wait=1 SHALL be ignored.
REQ-029 save_go while busy SHALL be ignored, with no err pulse.

Reset
REQ-030 On reset the FSM SHALL enter IDLE and all outputs SHALL be 0 (mem_rd, mem_addr, up_wait, up_din, file_size, busy, err).
REQ-031 Reset during a save SHALL abort it immediately; no further mem_rd SHALL be issued.

Structure
REQ-032 The record type constants (0x01 data, 0x02 transfer), the maximum chunk size 256, and the FSM state enum SHALL reside in a shared package, cmd_pkg, also usable by the loader.
REQ-033 The implementation SHALL be a single module with no sub-modules; the file_size arithmetic SHALL be registered combinational logic inside it.

Verification
REQ-034 Bench scenario, 3-byte save: start=0x5200, end=0x5202, exec=0x5200, RAM=AA BB CC -> file_size=11; stream 01 05 00 52 AA BB CC 02 02 00 52.
REQ-035 Bench scenario, full 256-byte chunk: start=0x6000, end=0x60FF -> second byte 0x02; file_size=264; final four bytes 02 02 lo hi.
REQ-036 Bench scenario, 257-byte range: start=0x6000, end=0x6100 -> second record 01 03 00 61 plus 1 byte; file_size=269.
REQ-037 Bench scenario, top of memory: start=0xFF00, end=0xFFFF -> one record 01 02 00 FF; no mem_addr 0x0000 is issued; busy clears after the transfer record.
REQ-038 Bench scenario, bad range: start=0x7000, end=0x6FFF -> err pulses once, busy=0, up_rd returns 0x00.
REQ-039 Bench scenario, reset mid-DATA: reset after 10 bytes -> next cycle IDLE, busy=0, no mem_rd; a new save_go restarts from the first record byte 0x01.
